// File: rtl/ex_div_ctrl_pkg.sv
// Shared encodings for the EX-stage RV32M divide sequencer.
// func3 codes of the divide group and the sequencer state type.
package ex_div_ctrl_pkg;

    localparam logic [2:0] INST_DIV     = 3'b100;
    localparam logic [2:0] INST_DIVU    = 3'b101;
    localparam logic [2:0] INST_REM     = 3'b110;
    localparam logic [2:0] INST_REMU    = 3'b111;
    localparam logic [6:0] INST_FUNC7_M = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_CALC  = 2'd2,
        ST_END   = 2'd3
    } div_state_e;

endpackage

// File: rtl/ex_div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU; holds the pipeline while busy
// and presents a one-cycle writeback pulse on completion.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start_i; operands captured on acceptance
// ST_START | special cases resolved, magnitudes and result signs taken
// ST_CALC  | one quotient bit per cycle, cnt_q counts down to 0
// ST_END   | sign fix-up, result/ready/rd_wen presented for one cycle
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  dividend_i,
    input  logic [XLEN-1:0]  divisor_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic [XLEN-1:0]  result_o,
    output logic             ready_o,
    output logic [4:0]       rd_addr_o,
    output logic             rd_wen_o,
    output logic             busy_o,
    output logic             hold_flag_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       rd_q;
    logic             q_neg_q;
    logic             r_neg_q;

    logic             op_signed;
    logic [XLEN:0]    step_t;
    logic             step_ge;
    logic [XLEN-1:0]  step_sub;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic             in_end;

    assign op_signed = (op_q == INST_DIV) || (op_q == INST_REM);

    // The shifted partial remainder can exceed XLEN bits for large unsigned divisors, so the
    // compare uses XLEN+1 bits; the difference itself always fits back into XLEN bits.
    always_comb begin
        step_t   = {rem_q, dvd_q[cnt_q]};
        step_ge  = (step_t >= {1'b0, dvs_q});
        step_sub = step_t[XLEN-1:0] - dvs_q;
    end

    assign quo_fix = q_neg_q ? XLEN'(~quo_q + 1'b1) : quo_q;
    assign rem_fix = r_neg_q ? XLEN'(~rem_q + 1'b1) : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q    <= op_i;
                        dvd_q   <= dividend_i;
                        dvs_q   <= divisor_i;
                        rd_q    <= rd_addr_i;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else if (dvs_q == '0) begin
                        quo_q   <= '1;
                        rem_q   <= dvd_q;
                        q_neg_q <= 1'b0;
                        r_neg_q <= 1'b0;
                        state_q <= ST_END;
                    end else if (op_signed && dvd_q == INT_MIN && dvs_q == '1) begin
                        quo_q   <= INT_MIN;
                        rem_q   <= '0;
                        q_neg_q <= 1'b0;
                        r_neg_q <= 1'b0;
                        state_q <= ST_END;
                    end else begin
                        dvd_q   <= (op_signed && dvd_q[XLEN-1]) ? XLEN'(~dvd_q + 1'b1) : dvd_q;
                        dvs_q   <= (op_signed && dvs_q[XLEN-1]) ? XLEN'(~dvs_q + 1'b1) : dvs_q;
                        q_neg_q <= op_signed && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                        r_neg_q <= op_signed && dvd_q[XLEN-1];
                        quo_q   <= '0;
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(XLEN - 1);
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rem_q        <= step_ge ? step_sub : step_t[XLEN-1:0];
                        quo_q[cnt_q] <= step_ge;
                        if (cnt_q == '0) begin
                            state_q <= ST_END;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // flush_i suppresses the writeback and hold in the same cycle it arrives.
    assign in_end      = (state_q == ST_END);
    assign ready_o     = in_end && !flush_i;
    assign rd_wen_o    = ready_o;
    assign result_o    = ready_o ? (op_q[1] ? rem_fix : quo_fix) : '0;
    assign rd_addr_o   = ready_o ? rd_q : '0;
    assign busy_o      = (state_q != ST_IDLE);
    assign hold_flag_o = !flush_i &&
                         (((state_q == ST_IDLE) && start_i) ||
                          (state_q == ST_START) || (state_q == ST_CALC));

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: per-cycle comparison against a latency/result model,
// directed literal cases and a randomized phase.
module tb_ex_div_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [2:0]      op_i;
    logic [31:0]     dividend_i;
    logic [31:0]     divisor_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic [31:0]     result_o;
    logic            ready_o;
    logic [4:0]      rd_addr_o;
    logic            rd_wen_o;
    logic            busy_o;
    logic            hold_flag_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res  = '0;
    logic [4:0]  m_rd   = '0;

    ex_div_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .result_o(result_o), .ready_o(ready_o),
        .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o), .busy_o(busy_o),
        .hold_flag_o(hold_flag_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        bit ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b111:  return (b == 0) ? a : a % b;
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            default: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
        endcase
    endfunction

    function automatic bit is_short(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
        return (b == 0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: idle, or busy with a count of cycles left before the writeback cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (flush_i || m_left == 0) m_busy <= 1'b0;
            else m_left <= m_left - 1;
        end else if (start_i && !flush_i) begin
            m_busy <= 1'b1;
            m_left <= is_short(op_i, dividend_i, divisor_i) ? 1 : XLEN + 1;
            m_res  <= ref_div(op_i, dividend_i, divisor_i);
            m_rd   <= rd_addr_i;
        end
    end

    always @(negedge clk) begin
        bit e_ready;
        bit e_hold;
        if (chk_en) begin
            e_ready = m_busy && (m_left == 0) && !flush_i;
            e_hold  = !flush_i && ((!m_busy && start_i) || (m_busy && m_left > 0));
            chk("ready_o",     32'(ready_o),     32'(e_ready));
            chk("rd_wen_o",    32'(rd_wen_o),    32'(e_ready));
            chk("busy_o",      32'(busy_o),      32'(m_busy));
            chk("hold_flag_o", 32'(hold_flag_o), 32'(e_hold));
            chk("result_o",    result_o,         e_ready ? m_res : 32'h0);
            chk("rd_addr_o",   32'(rd_addr_o),   e_ready ? 32'(m_rd) : 32'h0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        int          hold_cnt;
        bit          got;
        logic [31:0] res;
        lat = -1; hold_cnt = 0; got = 1'b0; res = '0;
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
        @(negedge clk);
        if (hold_flag_o) hold_cnt++;
        next_cycle();
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        op_i       = 3'b100 | 3'($urandom_range(0, 3));
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (hold_flag_o) hold_cnt++;
            if (ready_o) begin
                got = 1'b1;
                lat = k;
                res = result_o;
            end
            next_cycle();
        end
        chk({name, " result"},  res,          exp_res);
        chk({name, " latency"}, 32'(lat),      32'(exp_lat));
        chk({name, " hold"},    32'(hold_cnt), 32'(exp_lat));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_rdy;
        logic [31:0] cap;
        rst = 1'b1; start_i = 1'b0; op_i = 3'b100; dividend_i = '0; divisor_i = '0;
        rd_addr_i = '0; flush_i = 1'b0;
        next_cycle();
        chk_en = 1'b1;
        chk("reset ready",  32'(ready_o),     32'h0);
        chk("reset busy",   32'(busy_o),      32'h0);
        chk("reset hold",   32'(hold_flag_o), 32'h0);
        chk("reset result", result_o,         32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        do_op("divu 100/7",      3'b101, 32'd100,        32'd7,          5'd3,  32'd14,         34);
        do_op("div -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  34);
        do_op("rem -7/2",        3'b110, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFF,  34);
        do_op("remu fff9/2",     3'b111, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'd1,          34);
        do_op("divu fff9/2",     3'b101, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'h7FFF_FFFC,  34);
        do_op("div 5/0",         3'b100, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF,  2);
        do_op("remu 5/0",        3'b111, 32'd5,          32'd0,          5'd9,  32'd5,          2);
        do_op("div ovf",         3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  2);
        do_op("rem ovf",         3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h0,          2);
        do_op("divu max/1",      3'b101, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'hFFFF_FFFF,  34);
        do_op("remu big",        3'b111, 32'hFFFF_FFFF,  32'h8000_0001,  5'd12, 32'h7FFF_FFFE,  34);
        do_op("div min/2",       3'b100, 32'h8000_0000,  32'd2,          5'd13, 32'hC000_0000,  34);
        do_op("rem 7/-3",        3'b110, 32'd7,          32'hFFFF_FFFD,  5'd14, 32'd1,          34);

        // Flush in cycle 10, new op accepted in cycle 11.
        start_i = 1'b1; op_i = 3'b101; dividend_i = 32'd1234; divisor_i = 32'd5; rd_addr_i = 5'd1;
        next_cycle();
        start_i = 1'b0;
        n_rdy = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ready_o || rd_wen_o) n_rdy++;
            next_cycle();
        end
        flush_i = 1'b1;
        @(negedge clk);
        if (ready_o || rd_wen_o) n_rdy++;
        next_cycle();
        flush_i = 1'b0;
        chk("flush no ready", 32'(n_rdy),  32'h0);
        chk("flush idle",     32'(busy_o), 32'h0);
        do_op("after flush",  3'b101, 32'd1000, 32'd10, 5'd2, 32'd100, 34);

        // Reset in mid-CALC.
        start_i = 1'b1; op_i = 3'b100; dividend_i = 32'd999; divisor_i = 32'd3; rd_addr_i = 5'd9;
        next_cycle();
        start_i = 1'b0;
        repeat (14) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("rst busy",   32'(busy_o),      32'h0);
        chk("rst hold",   32'(hold_flag_o), 32'h0);
        chk("rst ready",  32'(ready_o),     32'h0);
        chk("rst result", result_o,         32'h0);
        next_cycle();

        // start_i pulses while busy are ignored.
        start_i = 1'b1; op_i = 3'b111; dividend_i = 32'd1000; divisor_i = 32'd7; rd_addr_i = 5'd15;
        next_cycle();
        start_i = 1'b0;
        n_rdy = 0; cap = '0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5 || k == 20) begin
                start_i = 1'b1; op_i = 3'b101; dividend_i = $urandom; divisor_i = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            if (ready_o) begin
                n_rdy++;
                cap = result_o;
            end
            next_cycle();
        end
        start_i = 1'b0;
        chk("busy start one ready", 32'(n_rdy), 32'd1);
        chk("busy start result",    cap,        32'd6);

        // Randomized traffic, checked every cycle by the model.
        n_rdy = 0;
        for (int k = 0; k < 3000; k++) begin
            start_i    = ($urandom_range(0, 3) == 0);
            flush_i    = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 799) == 0);
            op_i       = 3'b100 | 3'($urandom_range(0, 3));
            dividend_i = pick_operand();
            divisor_i  = pick_operand();
            rd_addr_i  = 5'($urandom);
            @(negedge clk);
            if (ready_o) n_rdy++;
            next_cycle();
        end
        start_i = 1'b0; flush_i = 1'b0; rst = 1'b0;
        chk("random completions", 32'(n_rdy > 20), 32'h1);
        repeat (40) next_cycle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
